// File: rtl/bootrom_port.sv
// rtl/bootrom_port.sv - two-channel round-robin sequential access port for the boot ROM
// Fetch and uncached-load requests are queued per channel; one ROM lookup per cycle.

module bootrom_port_queue #(
  parameter int W     = 35,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          wr_en;
  logic          rd_en;

  // full is a register tracking the pre-edge occupancy, so a push into a full queue is refused
  // even when the head is leaving in the same cycle
  assign wr_en     = push && !full;
  assign rd_en     = pop && not_empty;
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (wr_en && !rd_en) begin
      count_next = count + (PW+1)'(1);
    end else if (rd_en && !wr_en) begin
      count_next = count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

module bootrom_port #(
  parameter int ADDR_W         = 32,
  parameter int ROM_LINES_LOG2 = 9,
  parameter int TRANS_W        = 3,
  parameter int QDEPTH         = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rom_disable,
  input  logic                      ic_req,
  input  logic [ADDR_W-1:0]         ic_addr,
  input  logic [TRANS_W-1:0]        ic_trans,
  output logic                      ic_busy,
  output logic                      ic_rdy,
  output logic [127:0]              ic_data,
  output logic [TRANS_W-1:0]        ic_rtrans,
  output logic                      ic_err,
  input  logic                      ld_req,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [TRANS_W-1:0]        ld_trans,
  output logic                      ld_busy,
  output logic                      ld_rdy,
  output logic [63:0]               ld_data,
  output logic [TRANS_W-1:0]        ld_rtrans,
  output logic                      ld_err,
  output logic [ROM_LINES_LOG2-1:0] rom_addr,
  input  logic [127:0]              rom_data
);
  localparam int QW = ADDR_W + TRANS_W;
  localparam int HI = ROM_LINES_LOG2 + 3;

  logic [QW-1:0]             ic_head;
  logic [QW-1:0]             ld_head;
  logic                      ic_ne;
  logic                      ld_ne;
  logic                      grant_ic;
  logic                      grant_ld;
  logic                      last_ld;
  logic [ADDR_W-1:0]         sel_addr;
  logic [TRANS_W-1:0]        sel_trans;
  logic                      sel_err;
  logic [ROM_LINES_LOG2-1:0] rom_addr_q;
  logic                      unused_low;

  bootrom_port_queue #(.W(QW), .DEPTH(QDEPTH)) u_ic_q (
    .clk       (clk),
    .reset     (reset),
    .push      (ic_req),
    .push_data ({ic_addr, ic_trans}),
    .pop       (grant_ic),
    .head      (ic_head),
    .not_empty (ic_ne),
    .full      (ic_busy)
  );

  bootrom_port_queue #(.W(QW), .DEPTH(QDEPTH)) u_ld_q (
    .clk       (clk),
    .reset     (reset),
    .push      (ld_req),
    .push_data ({ld_addr, ld_trans}),
    .pop       (grant_ld),
    .head      (ld_head),
    .not_empty (ld_ne),
    .full      (ld_busy)
  );

  // a lone requester always wins; on a tie the channel not granted last goes
  always_comb begin
    grant_ic = ic_ne && (!ld_ne || last_ld);
    grant_ld = ld_ne && !grant_ic;
  end

  always_comb begin
    if (grant_ld) begin
      {sel_addr, sel_trans} = ld_head;
    end else begin
      {sel_addr, sel_trans} = ic_head;
    end
  end

  assign sel_err    = rom_disable || (sel_addr[ADDR_W-1:HI+1] != '0);
  assign rom_addr   = (grant_ic || grant_ld) ? sel_addr[HI:4] : rom_addr_q;
  assign unused_low = ^sel_addr[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ld    <= 1'b1;
      rom_addr_q <= '0;
      ic_rdy     <= 1'b0;
      ic_err     <= 1'b0;
      ic_data    <= '0;
      ic_rtrans  <= '0;
      ld_rdy     <= 1'b0;
      ld_err     <= 1'b0;
      ld_data    <= '0;
      ld_rtrans  <= '0;
    end else begin
      ic_rdy <= grant_ic;
      ld_rdy <= grant_ld;
      ic_err <= grant_ic && sel_err;
      ld_err <= grant_ld && sel_err;
      if (ic_ne && ld_ne) last_ld <= grant_ld;
      if (grant_ic || grant_ld) rom_addr_q <= sel_addr[HI:4];
      if (grant_ic) begin
        ic_rtrans <= sel_trans;
        ic_data   <= sel_err ? '0 : rom_data;
      end
      if (grant_ld) begin
        ld_rtrans <= sel_trans;
        ld_data   <= sel_err ? '0 : (sel_addr[3] ? rom_data[127:64] : rom_data[63:0]);
      end
    end
  end
endmodule

// File: tb/tb_bootrom_port.sv
// tb/tb_bootrom_port.sv - scoreboard bench for bootrom_port
// Stimulus pushes expected responses per channel; a negedge monitor pops and compares.

module tb_bootrom_port;
  logic         clk = 1'b0;
  logic         reset;
  logic         rom_disable;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic [2:0]   ic_trans;
  logic         ic_busy;
  logic         ic_rdy;
  logic [127:0] ic_data;
  logic [2:0]   ic_rtrans;
  logic         ic_err;
  logic         ld_req;
  logic [31:0]  ld_addr;
  logic [2:0]   ld_trans;
  logic         ld_busy;
  logic         ld_rdy;
  logic [63:0]  ld_data;
  logic [2:0]   ld_rtrans;
  logic         ld_err;
  logic [8:0]   rom_addr;
  logic [127:0] rom_data;

  typedef struct {
    logic [2:0]   trans;
    logic         err;
    logic [127:0] data;
  } exp_t;

  exp_t ic_q[$];
  exp_t ld_q[$];
  exp_t me;
  int   order_log[$];
  int   stamp_log[$];
  int   cycnt = 0;
  int   ic_busy_cycles = 0;
  int   ld_busy_cycles = 0;
  int   tests = 0;
  int   fails = 0;

  bootrom_port dut (
    .clk(clk), .reset(reset), .rom_disable(rom_disable),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_trans(ic_trans), .ic_busy(ic_busy),
    .ic_rdy(ic_rdy), .ic_data(ic_data), .ic_rtrans(ic_rtrans), .ic_err(ic_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_trans(ld_trans), .ld_busy(ld_busy),
    .ld_rdy(ld_rdy), .ld_data(ld_data), .ld_rtrans(ld_rtrans), .ld_err(ld_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rom_line(input logic [8:0] i);
    logic [31:0] x;
    x = {23'h0, i};
    return {32'hA5A0_0000 | x, 32'h5B50_0000 | x, 32'hC3C0_0000 | x, 32'h1D10_0000 | x};
  endfunction

  assign rom_data = rom_line(rom_addr);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t ic_exp(input logic [31:0] a, input logic [2:0] t);
    exp_t e;
    e.trans = t;
    e.err   = rom_disable || (a[31:13] != 0);
    e.data  = e.err ? 128'h0 : rom_line(a[12:4]);
    return e;
  endfunction

  function automatic exp_t ld_exp(input logic [31:0] a, input logic [2:0] t);
    exp_t e;
    logic [127:0] line;
    line    = rom_line(a[12:4]);
    e.trans = t;
    e.err   = rom_disable || (a[31:13] != 0);
    e.data  = e.err ? 128'h0 : {64'h0, (a[3] ? line[127:64] : line[63:0])};
    return e;
  endfunction

  function automatic logic [15:0] order_bits(input int base);
    logic [15:0] b;
    b = '0;
    for (int i = base; i < order_log.size() && (i - base) < 16; i++) b[i-base] = order_log[i][0];
    return b;
  endfunction

  always @(posedge clk) cycnt <= cycnt + 1;

  always @(negedge clk) begin
    if (ic_busy === 1'b1) ic_busy_cycles++;
    if (ld_busy === 1'b1) ld_busy_cycles++;
    if (ic_rdy || ld_rdy) chk("one_rdy_per_cycle", ic_rdy & ld_rdy, 0);
    if (ic_rdy) begin
      order_log.push_back(0);
      stamp_log.push_back(cycnt);
      if (ic_q.size() == 0) chk("ic_unexpected_rdy", ic_rdy, 0);
      else begin
        me = ic_q.pop_front();
        chk("ic_rtrans", ic_rtrans, me.trans);
        chk("ic_err", ic_err, me.err);
        chk("ic_data", ic_data, me.data);
      end
    end
    if (ld_rdy) begin
      order_log.push_back(1);
      stamp_log.push_back(cycnt);
      if (ld_q.size() == 0) chk("ld_unexpected_rdy", ld_rdy, 0);
      else begin
        me = ld_q.pop_front();
        chk("ld_rtrans", ld_rtrans, me.trans);
        chk("ld_err", ld_err, me.err);
        chk("ld_data", {64'h0, ld_data}, me.data);
      end
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] ia, input logic [2:0] it,
                     input logic lv, input logic [31:0] la, input logic [2:0] lt);
    if (iv) begin
      chk("ic_not_busy_at_req", ic_busy, 0);
      if (!ic_busy) begin
        ic_req = 1'b1; ic_addr = ia; ic_trans = it;
        ic_q.push_back(ic_exp(ia, it));
      end
    end
    if (lv) begin
      chk("ld_not_busy_at_req", ld_busy, 0);
      if (!ld_busy) begin
        ld_req = 1'b1; ld_addr = la; ld_trans = lt;
        ld_q.push_back(ld_exp(la, lt));
      end
    end
    @(posedge clk); #1;
    ic_req = 1'b0;
    ld_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((ic_q.size() != 0 || ld_q.size() != 0) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({name, "_drained"}, ic_q.size() + ld_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int sbase;
    int ldb0;
    int icb0;
    int pairs;
    int guard;

    reset = 1'b1; rom_disable = 1'b0;
    ic_req = 1'b0; ic_addr = '0; ic_trans = '0;
    ld_req = 1'b0; ld_addr = '0; ld_trans = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    chk("rst_ic_busy", ic_busy, 0);
    chk("rst_ld_busy", ld_busy, 0);
    chk("rst_ic_rdy", ic_rdy, 0);
    chk("rst_ld_rdy", ld_rdy, 0);
    chk("rst_ic_err", ic_err, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_ic_data", ic_data, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_ic_rtrans", ic_rtrans, 0);
    chk("rst_ld_rtrans", ld_rtrans, 0);

    // single fetch: rom_addr in N+1, response in N+2
    cyc(1, 32'h10, 3'd5, 0, 32'h0, 3'd0);
    chk("fetch_rom_addr_n1", rom_addr, 1);
    chk("fetch_rdy_n1", ic_rdy, 0);
    @(posedge clk); #1;
    chk("fetch_rdy_n2", ic_rdy, 1);
    drain("fetch");

    // load halves back to back
    sbase = stamp_log.size();
    cyc(0, 32'h0, 3'd0, 1, 32'h0, 3'd1);
    cyc(0, 32'h0, 3'd0, 1, 32'h8, 3'd2);
    drain("ldhalf");
    chk("ldhalf_count", stamp_log.size() - sbase, 2);
    if (stamp_log.size() - sbase == 2) chk("ldhalf_consecutive", stamp_log[sbase+1] - stamp_log[sbase], 1);

    // out of range fetch, then disabled load
    cyc(1, 32'h2000, 3'd6, 0, 32'h0, 3'd0);
    drain("oor");
    rom_disable = 1'b1;
    cyc(0, 32'h0, 3'd0, 1, 32'h8, 3'd3);
    drain("disabled");
    rom_disable = 1'b0;

    // tie: four pairs issued whenever neither queue is full
    base = order_log.size();
    ldb0 = ld_busy_cycles;
    icb0 = ic_busy_cycles;
    pairs = 0;
    guard = 0;
    while (pairs < 4 && guard < 40) begin
      if (!ic_busy && !ld_busy) begin
        cyc(1, 32'h20 + 32'h10 * pairs, 3'(2 * pairs), 1, 32'h40 + 32'h8 * pairs, 3'(2 * pairs + 1));
        pairs++;
      end else begin
        idle(1);
      end
      guard++;
    end
    drain("tie");
    chk("tie_order_len", order_log.size() - base, 8);
    chk("tie_order", order_bits(base), 16'h00AA);
    chk("tie_ld_busy_cycles", ld_busy_cycles - ldb0, 3);
    chk("tie_ic_busy_cycles", ic_busy_cycles - icb0, 0);

    // reset mid-flight: two loads discarded, no responses
    base = order_log.size();
    ld_req = 1'b1; ld_addr = 32'h30; ld_trans = 3'd1;
    @(posedge clk); #1;
    ld_addr = 32'h38; ld_trans = 3'd2; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ld_req = 1'b0;
    chk("midrst_ld_busy", ld_busy, 0);
    chk("midrst_ic_busy", ic_busy, 0);
    chk("midrst_ld_rdy", ld_rdy, 0);
    chk("midrst_ld_data", ld_data, 0);
    chk("midrst_ic_data", ic_data, 0);
    idle(3);
    cyc(1, 32'h60, 3'd4, 1, 32'h68, 3'd5);
    drain("midrst_tie");
    chk("midrst_order_len", order_log.size() - base, 2);
    chk("midrst_order", order_bits(base), 16'h0002);

    // backpressure: three consecutive fetches while loads contend
    do_reset();
    base = order_log.size();
    cyc(1, 32'h70, 3'd1, 1, 32'h80, 3'd2);
    cyc(1, 32'h90, 3'd2, 1, 32'h88, 3'd3);
    cyc(1, 32'hA0, 3'd3, 0, 32'h0, 3'd0);
    chk("bp_ic_busy", ic_busy, 1);
    chk("bp_ld_busy", ld_busy, 0);
    cyc(0, 32'h0, 3'd0, 1, 32'h98, 3'd4);
    drain("bp");
    chk("bp_order_len", order_log.size() - base, 6);
    chk("bp_order", order_bits(base), 16'h002A);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
